inst_fetch_unit: RTL and testbench
==================================

// Module: inst_fetch_unit
// PURPOSE
//  Instruction-fetch stage: owns the PC and instruction memory, and drives Instruction_Code/PC_instFetch into IF/ID.
//  Memory is loaded through a program port while idle; start launches fetch from address 0.
//  Jumps (opcode 2'b11) redirect the PC in-stage; stall freezes fetch; a jump-to-self halts.
// PARAMETERS
//  PC_W     8      PC / memory address width; DEPTH = 2**PC_W
//  INSTR_W  8      instruction width; fields [7:6] opcode, [5:3] Rd, [2:0] Rs
// PORTS
//  clk             in   1        clock, rising edge
//  Reset           in   1        asynchronous, active-low reset
//  prog_we         in   1        program-port write strobe, honoured in IDLE only
//  prog_addr       in   PC_W     program-port address
//  prog_data       in   INSTR_W  program-port data
//  start           in   1        IDLE->RUN launch; HALT->IDLE return
//  stall           in   1        hazard stall from downstream; freezes PC and outputs
//  Instruction_Code out INSTR_W  instruction at PC_instFetch; 8'h00 when if_valid=0
//  PC_instFetch    out  PC_W     current fetch PC (registered)
//  if_valid        out  1        1 only in RUN; downstream treats 0 as bubble
//  halted          out  1        1 in HALT
// BEHAVIOUR
//  - Reset (async, Reset=0): state=IDLE, PC=0, if_valid=0, halted=0, Instruction_Code=0. Memory is NOT cleared.
//  - Reset mid-RUN aborts fetch immediately. Memory contents survive.
//  - FSM IDLE/RUN/HALT.
//    - IDLE --start--> RUN. PC stays 0.
//    - RUN --jump-to-self fetched, not stalled--> HALT.
//    - HALT --start--> IDLE. PC<=0.
//  - IDLE: prog_we writes mem[prog_addr]<=prog_data at the clock edge.
//  - prog_we together with start in IDLE: the write commits, and the first RUN cycle sees the new data.
//  - prog_we in RUN/HALT is ignored.
//  - Instruction_Code = mem[PC_instFetch] by combinational (async) read, gated to 0 unless state==RUN.
//    - Zero latency from PC register to instruction.
//    - if_valid = (state==RUN), decoded from the state register; no combinational path from inputs.
//  - RUN, stall=1: PC held, state held, outputs stable. Stall has priority over jump and over halt detection.
//  - RUN, stall=0:
//    - opcode==2'b11: PC <= {{(PC_W-6){1'b0}}, instr[5:0]} (zero-extended).
//    - Otherwise PC <= PC+1, modulo 2**PC_W (8'hFF -> 8'h00, no flag).
//  - Jump-to-self (opcode 11, target==PC): the instruction is presented once with if_valid=1, then state=HALT, PC frozen.
//  - start in RUN is ignored. stall in IDLE/HALT is ignored.
// STRUCTURE
//  - Shared package fetch_pkg holds:
//    - OPC_JMP=2'b11
//    - field-slice localparams (OPC_HI/LO, RD_HI/LO, RS_HI/LO, JTGT_W=6)
//    - fetch-state encoding: IDLE=2'd0, RUN=2'd1, HALT=2'd2
//  - Sub-module inst_mem: DEPTH x INSTR_W, sync write (we/waddr/wdata), async read (raddr->rdata), no reset.
//  - Top holds the FSM, the PC register, next-PC mux and output gating.
// TESTING
//  1 Reset=0 at any time -> PC_instFetch=0, Instruction_Code=0, if_valid=0, halted=0. A prior mem write is still readable after restart.
//  2 Load mem[0..2]=8'h09,8'h12,8'h1B; pulse start.
//    -> cycles 1..3: (PC,instr,valid) = (00,09,1), (01,12,1), (02,1B,1).
//  3 stall=1 for 3 cycles while PC=01 -> PC=01, instr=12, valid=1 held.
//    -> first cycle after release shows PC=02.
//  4 mem[3]=8'hC8 (jmp 8), fetched unstalled -> next PC=08.
//    -> With stall=1 on that cycle, PC stays 03.
//  5 mem[8]=8'hC8 -> one valid cycle at PC=08, then halted=1, if_valid=0, Instruction_Code=0.
//    -> start -> IDLE; next start -> PC=00.
//  6 Memory filled with 8'h00, run 256+ cycles -> PC wraps FF->00 with if_valid continuous.
//    -> prog_we pulses during RUN leave memory unchanged (read back in IDLE).

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage:
// instruction field slices, jump opcode and fetch-state encoding.
package fetch_pkg;

   localparam logic [1:0] OPC_JMP = 2'b11;

   localparam int OPC_HI = 7;
   localparam int OPC_LO = 6;
   localparam int RD_HI  = 5;
   localparam int RD_LO  = 3;
   localparam int RS_HI  = 2;
   localparam int RS_LO  = 0;
   localparam int JTGT_W = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/inst_mem.sv
// Instruction memory: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module inst_mem #(
   parameter int AW = 8,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch stage: PC register, fetch FSM, jump redirect
// and IF/ID output gating around a program-loadable memory.
module inst_fetch_unit
   import fetch_pkg::*;
#(
   parameter int PC_W    = 8,
   parameter int INSTR_W = 8
) (
   input  logic               clk,
   input  logic               Reset,
   input  logic               prog_we,
   input  logic [PC_W-1:0]    prog_addr,
   input  logic [INSTR_W-1:0] prog_data,
   input  logic               start,
   input  logic               stall,
   output logic [INSTR_W-1:0] Instruction_Code,
   output logic [PC_W-1:0]    PC_instFetch,
   output logic               if_valid,
   output logic               halted
);

   fetch_state_t       state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [INSTR_W-1:0] instr_raw;
   logic [PC_W-1:0]    jtgt;
   logic               is_jmp;
   logic               mem_we;

   inst_mem #(
      .AW (PC_W),
      .DW (INSTR_W)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (prog_addr),
      .wdata (prog_data),
      .raddr (pc_q),
      .rdata (instr_raw)
   );

   assign is_jmp = (instr_raw[OPC_HI:OPC_LO] == OPC_JMP);
   assign jtgt   = {{(PC_W-JTGT_W){1'b0}}, instr_raw[JTGT_W-1:0]};

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
         pc_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      mem_we  = 1'b0;
      unique case (state_q)
         IDLE: begin
            mem_we = prog_we;
            if (start) state_d = RUN;
         end
         RUN: begin
            // stall outranks both the redirect and halt detection
            if (!stall) begin
               if (is_jmp && (jtgt == pc_q)) begin
                  state_d = HALT;
               end else if (is_jmp) begin
                  pc_d = jtgt;
               end else begin
                  pc_d = pc_q + 1'b1;
               end
            end
         end
         HALT: begin
            if (start) begin
               state_d = IDLE;
               pc_d    = '0;
            end
         end
         default: begin
            state_d = IDLE;
            pc_d    = '0;
         end
      endcase
   end

   assign if_valid         = (state_q == RUN);
   assign halted           = (state_q == HALT);
   assign PC_instFetch     = pc_q;
   assign Instruction_Code = if_valid ? instr_raw : '0;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios plus
// randomized programs against a behavioural fetch model.
module tb_inst_fetch_unit;

   logic       clk;
   logic       Reset;
   logic       prog_we;
   logic [7:0] prog_addr;
   logic [7:0] prog_data;
   logic       start;
   logic       stall;
   logic [7:0] Instruction_Code;
   logic [7:0] PC_instFetch;
   logic       if_valid;
   logic       halted;

   int total = 0;
   int bad   = 0;

   // reference model
   logic [7:0] m_mem [256];
   logic [7:0] m_pc;
   bit         m_running;
   bit         m_halted;

   inst_fetch_unit dut (
      .clk              (clk),
      .Reset            (Reset),
      .prog_we          (prog_we),
      .prog_addr        (prog_addr),
      .prog_data        (prog_data),
      .start            (start),
      .stall            (stall),
      .Instruction_Code (Instruction_Code),
      .PC_instFetch     (PC_instFetch),
      .if_valid         (if_valid),
      .halted           (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_model(input string tag);
      logic [7:0] ei;
      ei = m_running ? m_mem[m_pc] : 8'h00;
      check({tag, "_pc"},    32'(PC_instFetch),     32'(m_pc));
      check({tag, "_instr"}, 32'(Instruction_Code), 32'(ei));
      check({tag, "_valid"}, 32'(if_valid),         32'(m_running));
      check({tag, "_halt"},  32'(halted),           32'(m_halted));
   endtask

   // one clock of the model, evaluated on pre-edge state
   task automatic model_edge(input bit we, input logic [7:0] a,
                             input logic [7:0] d, input bit st,
                             input bit sl);
      logic [7:0] ins;
      logic [7:0] tgt;
      if (m_running) begin
         if (!sl) begin
            ins = m_mem[m_pc];
            if (ins[7:6] == 2'b11) begin
               tgt = {2'b00, ins[5:0]};
               if (tgt == m_pc) begin
                  m_running = 0;
                  m_halted  = 1;
               end else begin
                  m_pc = tgt;
               end
            end else begin
               m_pc = 8'((int'(m_pc) + 1) % 256);
            end
         end
      end else if (m_halted) begin
         if (st) begin
            m_halted = 0;
            m_pc     = 8'h00;
         end
      end else begin
         if (we) m_mem[a] = d;
         if (st) m_running = 1;
      end
   endtask

   task automatic step(input bit we, input logic [7:0] a,
                       input logic [7:0] d, input bit st,
                       input bit sl, input string tag);
      prog_we   = we;
      prog_addr = a;
      prog_data = d;
      start     = st;
      stall     = sl;
      @(posedge clk);
      model_edge(we, a, d, st, sl);
      #1;
      check_model(tag);
   endtask

   task automatic do_reset();
      prog_we = 0;
      start   = 0;
      stall   = 0;
      #2;
      Reset = 1'b0;
      #1;
      m_running = 0;
      m_halted  = 0;
      m_pc      = 8'h00;
      check_model("rst_async");
      @(posedge clk);
      #1;
      check_model("rst_hold");
      Reset = 1'b1;
   endtask

   initial begin
      Reset     = 1'b0;
      prog_we   = 0;
      prog_addr = 0;
      prog_data = 0;
      start     = 0;
      stall     = 0;
      m_running = 0;
      m_halted  = 0;
      m_pc      = 0;
      for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
      @(posedge clk);
      #1;
      check("por_pc",    32'(PC_instFetch),     0);
      check("por_instr", 32'(Instruction_Code), 0);
      check("por_valid", 32'(if_valid),         0);
      check("por_halt",  32'(halted),           0);
      Reset = 1'b1;

      // zero-fill, then run through a full PC wrap
      for (int i = 0; i < 256; i++) step(1, 8'(i), 8'h00, 0, 0, "fill");
      step(0, 0, 0, 1, 0, "wrap_go");
      for (int i = 1; i <= 258; i++) begin
         step(($urandom % 4) == 0, 8'($urandom), 8'($urandom),
              0, 0, "wrap");
         if (i == 256) begin
            check("wrap_pc0",   32'(PC_instFetch), 0);
            check("wrap_valid", 32'(if_valid),     1);
         end
      end
      do_reset();

      // directed program
      step(1, 8'h00, 8'h09, 0, 0, "ld");
      step(1, 8'h01, 8'h12, 0, 0, "ld");
      step(1, 8'h02, 8'h1B, 0, 0, "ld");
      step(1, 8'h03, 8'hC8, 0, 0, "ld");
      step(1, 8'h08, 8'hC8, 1, 0, "ld_go");
      check("d_pc0", 32'(PC_instFetch),     32'h00);
      check("d_i0",  32'(Instruction_Code), 32'h09);
      step(0, 0, 0, 0, 0, "d1");
      check("d_i1",  32'(Instruction_Code), 32'h12);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0, 1, "stall");
         check("st_pc", 32'(PC_instFetch), 32'h01);
      end
      step(0, 0, 0, 0, 0, "d2");
      check("d_pc2", 32'(PC_instFetch), 32'h02);
      step(0, 0, 0, 0, 0, "d3");
      step(0, 0, 0, 0, 1, "jstall");
      check("js_pc", 32'(PC_instFetch), 32'h03);
      step(0, 0, 0, 0, 0, "jmp");
      check("j_pc",  32'(PC_instFetch), 32'h08);
      step(0, 0, 0, 0, 0, "halt");
      check("h_flag",  32'(halted),           1);
      check("h_instr", 32'(Instruction_Code), 0);
      step(0, 0, 0, 1, 0, "h2idle");
      step(0, 0, 0, 1, 0, "restart");
      check("r_pc", 32'(PC_instFetch), 32'h00);
      step(0, 0, 0, 0, 0, "r1");
      do_reset();

      // randomized programs
      for (int r = 0; r < 10; r++) begin
         for (int w = 0; w < 30; w++) begin
            logic [7:0] a, d;
            a = 8'($urandom);
            d = 8'($urandom);
            if (($urandom % 6) == 0) begin
               a = 8'($urandom % 64);
               d = 8'hC0 | a;
            end
            step(1, a, d, w == 29, 0, "rload");
         end
         for (int c = 0; c < 200; c++) begin
            if (m_halted) begin
               step(0, 0, 0, 1, 0, "rret");
               break;
            end
            step(($urandom % 10) == 0, 8'($urandom), 8'($urandom),
                 ($urandom % 10) == 0, ($urandom % 4) == 0, "rrun");
         end
         if (m_running) do_reset();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
